// File: rtl/muldiv_pkg.sv
`timescale 1ns/1ps
// Shared encodings and constants for the EX-stage multiply/divide unit.
package muldiv_pkg;

   localparam logic        OP_MUL    = 1'b0;
   localparam logic        OP_DIV    = 1'b1;
   localparam int unsigned OP_SIGNED = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Quotient reported for a divide by zero; truncated to the operand width at use.
   localparam logic [127:0] DIVZ_LO = '1;

endpackage

// File: rtl/muldiv_sign_fix.sv
`timescale 1ns/1ps
// Conditional two's-complement negate; serves as abs() at launch and sign fixup at the end.
module muldiv_sign_fix #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] result
);

   assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/ex_muldiv_unit.sv
`timescale 1ns/1ps
// Iterative radix-2 multiply / restoring divide unit for the EX stage.
// Optional signed support is enabled with `define MULDIV_SIGNED_EN.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_t           state, state_d;
   logic [CW-1:0]    cnt;
   logic [W2-1:0]    acc, acc_step;
   logic [WIDTH-1:0] opnd;
   logic             sgn_q, fix_pend, fix_pend_d;
   logic             busy_d, done_d;
   logic             launch, launch_dbz, last_iter, sgn_op;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] fix_hi, fix_lo;
   logic [WIDTH:0]   mul_sum, mul_add, div_rem, div_trial;

   assign launch     = (state == ST_IDLE) && start;
   assign launch_dbz = launch && (op[0] == OP_DIV) && (opB == '0);
   assign last_iter  = (cnt == CW'(1));
   assign stall      = busy | (start & (state == ST_IDLE));

`ifdef MULDIV_SIGNED_EN
   logic             neg_q, neg_r, div_q;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign sgn_op = op[OP_SIGNED];

   muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.value(opA), .negate(sgn_op & opA[WIDTH-1]), .result(mag_a));
   muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.value(opB), .negate(sgn_op & opB[WIDTH-1]), .result(mag_b));
   muldiv_sign_fix #(.W(W2))    u_fix_p (.value(acc), .negate(neg_q), .result(prod_fix));
   muldiv_sign_fix #(.W(WIDTH)) u_fix_q (.value(acc[WIDTH-1:0]), .negate(neg_q), .result(quo_fix));
   muldiv_sign_fix #(.W(WIDTH)) u_fix_r (.value(acc[W2-1:WIDTH]), .negate(neg_r), .result(rem_fix));

   assign fix_hi = div_q ? rem_fix : prod_fix[W2-1:WIDTH];
   assign fix_lo = div_q ? quo_fix : prod_fix[WIDTH-1:0];

   // Result sign rules captured at launch: product/quotient by sign XOR, remainder by dividend.
   always_ff @(posedge clock) begin
      if (reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         div_q <= 1'b0;
      end else if (launch) begin
         neg_q <= sgn_op & (opA[WIDTH-1] ^ opB[WIDTH-1]);
         neg_r <= sgn_op & opA[WIDTH-1];
         div_q <= (op[0] == OP_DIV);
      end
   end
`else
   logic unused_op_sign;

   assign unused_op_sign = op[OP_SIGNED];
   assign sgn_op         = 1'b0;
   assign mag_a          = opA;
   assign mag_b          = opB;
   assign fix_hi         = acc[W2-1:WIDTH];
   assign fix_lo         = acc[WIDTH-1:0];
`endif

   // One iteration: shift-add for multiply, trial-subtract for divide.
   always_comb begin
      mul_add   = acc[0] ? {1'b0, opnd} : '0;
      mul_sum   = {1'b0, acc[W2-1:WIDTH]} + mul_add;
      div_rem   = acc[W2-1:WIDTH-1];
      div_trial = div_rem - {1'b0, opnd};
      if (state == ST_DIV) begin
         if (!div_trial[WIDTH])
            acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_step = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d    = state;
      fix_pend_d = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (op[0] == OP_DIV)
                  state_d = (opB == '0) ? ST_DONE : ST_DIV;
               else
                  state_d = ST_MUL;
            end
         end
         ST_MUL, ST_DIV: begin
            if (last_iter) begin
               state_d    = ST_DONE;
               fix_pend_d = sgn_q;
            end
         end
         ST_DONE: begin
            if (!fix_pend)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
      done_d = (state_d == ST_DONE) && !fix_pend_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         acc         <= '0;
         opnd        <= '0;
         sgn_q       <= 1'b0;
         fix_pend    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         state    <= state_d;
         fix_pend <= fix_pend_d;
         busy     <= busy_d;
         done     <= done_d;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cnt         <= CW'(WIDTH);
                  sgn_q       <= sgn_op;
                  div_by_zero <= launch_dbz;
                  opnd        <= (op[0] == OP_DIV) ? mag_b : mag_a;
                  acc         <= {WIDTH'(0), (op[0] == OP_DIV) ? mag_a : mag_b};
                  if (launch_dbz) begin
                     hi <= opA;
                     lo <= WIDTH'(DIVZ_LO);
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               acc <= acc_step;
               cnt <= cnt - CW'(1);
               if (last_iter && !sgn_q) begin
                  hi <= acc_step[W2-1:WIDTH];
                  lo <= acc_step[WIDTH-1:0];
               end
            end
            ST_DONE: begin
               if (fix_pend) begin
                  hi <= fix_hi;
                  lo <= fix_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
`timescale 1ns/1ps
// Self-checking bench for ex_muldiv_unit: directed scenarios plus random ops vs. an arithmetic model.
module tb_ex_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset, start;
   logic [1:0]  op;
   logic [31:0] opA, opB;
   logic        busy, stall, done, div_by_zero;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;

   ex_muldiv_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
      .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

`ifdef MULDIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   // Expected results straight from arithmetic definitions.
   task automatic ref_model(input logic [1:0] o, input logic [31:0] a, b,
                            output logic [31:0] eh, el, output logic edbz, output int elat);
      bit          sgn;
      longint      sp;
      longint unsigned up;
      int          sa, sb;
      sgn  = SIGNED_EN && o[1];
      edbz = 1'b0;
      elat = sgn ? 34 : 33;
      if (o[0]) begin
         if (b == 32'd0) begin
            eh = a; el = 32'hFFFF_FFFF; edbz = 1'b1; elat = 1;
         end else if (sgn) begin
            sa = a; sb = b;
            el = sa / sb; eh = sa % sb;
         end else begin
            el = a / b; eh = a % b;
         end
      end else if (sgn) begin
         sa = a; sb = b;
         sp = longint'(sa) * longint'(sb);
         {eh, el} = sp;
      end else begin
         up = {32'd0, a} * {32'd0, b};
         {eh, el} = up;
      end
   endtask

   // Launch one operation and wait (bounded) for done; operands are scrambled after launch.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, b,
                         output int lat, output int bcnt, output int sbad, output logic s0,
                         output logic [31:0] rh, rl, output logic rdbz);
      @(negedge clock);
      op = o; opA = a; opB = b; start = 1'b1;
      #1 s0 = stall;
      @(negedge clock);
      start = 1'b0; opA = $urandom; opB = $urandom; op = 2'($urandom_range(0, 3));
      #1;
      lat = 1; bcnt = 0; sbad = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) bcnt++;
         if (stall !== busy) sbad++;
         @(negedge clock);
         lat++;
      end
      rh = hi; rl = lo; rdbz = div_by_zero;
   endtask

   // Full comparison of one operation against the model.
   task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a, b);
      int lat, bcnt, sbad, elat;
      logic s0, rdbz, edbz;
      logic [31:0] rh, rl, eh, el;
      ref_model(o, a, b, eh, el, edbz, elat);
      run_op(o, a, b, lat, bcnt, sbad, s0, rh, rl, rdbz);
      checks += 6;
      if (lat !== elat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat); end
      if (rh !== eh) begin failures++; $display("FAIL %s hi got=%h exp=%h", name, rh, eh); end
      if (rl !== el) begin failures++; $display("FAIL %s lo got=%h exp=%h", name, rl, el); end
      if (rdbz !== edbz) begin failures++; $display("FAIL %s div_by_zero got=%b exp=%b", name, rdbz, edbz); end
      if (bcnt !== ((elat == 1) ? 0 : 32)) begin
         failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, bcnt, (elat == 1) ? 0 : 32);
      end
      if (s0 !== 1'b1 || sbad !== 0) begin
         failures++; $display("FAIL %s stall launch=%b mismatches=%0d exp launch=1 mismatches=0", name, s0, sbad);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
      repeat (3) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got busy=%b done=%b dbz=%b hi=%h lo=%h stall=%b exp all zero",
                  busy, done, div_by_zero, hi, lo, stall);
      end
      reset = 1'b0;
   endtask

   task automatic test_mul();
      check_op("mul_7x6", 2'b00, 32'd7, 32'd6);
      check_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         failures++; $display("FAIL mul_max_const got=%h_%h exp=fffffffe_00000001", hi, lo);
      end
   endtask

   task automatic test_div();
      check_op("div_100_7", 2'b01, 32'd100, 32'd7);
      check_op("div_by_zero", 2'b01, 32'd100, 32'd0);
      repeat (5) @(negedge clock);
      checks++;
      if (div_by_zero !== 1'b1 || hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin
         failures++; $display("FAIL dbz_sticky got dbz=%b hi=%h lo=%h exp 1/64/ffffffff", div_by_zero, hi, lo);
      end
      check_op("dbz_clear", 2'b00, 32'd3, 32'd5);
   endtask

   task automatic test_start_ignored();
      int npulse = 0, first = 0;
      logic [31:0] rl = '0, rh = '1;
      @(negedge clock);
      op = 2'b00; opA = 32'd7; opB = 32'd6; start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         start = (c == 10);
         opA   = (c == 10) ? 32'd3 : 32'd7;
         #1;
         if (done === 1'b1) begin
            npulse++;
            if (first == 0) begin first = c; rl = lo; rh = hi; end
         end
      end
      start = 1'b0;
      checks++;
      if (npulse !== 1 || first !== 33 || rl !== 32'd42 || rh !== 32'd0) begin
         failures++; $display("FAIL start_ignored pulses=%0d at=%0d lo=%0d hi=%0d exp 1/33/42/0", npulse, first, rl, rh);
      end
   endtask

   task automatic test_back_to_back();
      check_op("b2b_first", 2'b00, 32'd12345, 32'd678);
      check_op("b2b_second", 2'b01, 32'd1000000, 32'd999);
      check_op("b2b_third", 2'b01, 32'hDEAD_BEEF, 32'd0);
      check_op("b2b_fourth", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      @(negedge clock);
      op = 2'b01; opA = 32'd1000; opB = 32'd3; start = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clock);
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || div_by_zero !== 1'b0) begin
         failures++; $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h dbz=%b exp all zero",
                              busy, done, hi, lo, div_by_zero);
      end
      reset = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin failures++; $display("FAIL reset_mid_quiet active_cycles=%0d exp=0", pulses); end
   endtask

   task automatic test_signed();
      check_op("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2);
      checks++;
      if (SIGNED_EN) begin
         if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL sdiv_const got hi=%h lo=%h exp ffffffff/fffffffd", hi, lo);
         end
      end else if (lo !== 32'd2147483644 || hi !== 32'd1) begin
         failures++; $display("FAIL udiv_op11_const got hi=%h lo=%h exp 1/7ffffffc", hi, lo);
      end
      check_op("smul_m7_6", 2'b10, 32'hFFFF_FFF9, 32'd6);
      check_op("op11_100_7", 2'b11, 32'd100, 32'd7);
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 3))
            0: b = b & 32'hF;
            1: a = a & 32'hFF;
            default: ;
         endcase
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         check_op($sformatf("random_%0d", i), o, a, b);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_signed();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
